// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
//  Module   : pipe_stall_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage pipeline. It merges the
//             load-use, branch, bus-wait and divide events into per-stage
//             enable and flush controls. The optional stall counter is built
//             only when PIPE_STALL_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_stall,
    input  logic        br_taken,
    input  logic        imem_wait,
    input  logic        dmem_wait,
    input  logic        div_req,
    output logic        pc_en,
    output logic        pc_sel_redir,
    output logic        redir_ld,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        pc_sel_redir = 1'b0;
        redir_ld     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        div_busy     = 1'b0;
        div_done     = 1'b0;
        w_nextState  = r_state;
        w_cntNext    = r_cnt;

        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (dmem_wait) begin
            // A pending data access freezes the whole pipe, divide counter included.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            div_busy  = (r_state == ST_DIV);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (div_req) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        w_cntNext    = CNT_W'(DIV_LAT - 1);
                        w_nextState  = ST_DIV;
                    end else if (br_taken && !imem_wait) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (br_taken) begin
                        // Fetch still in flight: park the target until the bus frees up.
                        pc_en       = 1'b0;
                        redir_ld    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_nextState = ST_REDIR;
                    end else if (lu_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (imem_wait) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                ST_DIV: begin
                    div_busy = 1'b1;
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    if (r_cnt != '0) begin
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        w_cntNext    = r_cnt - CNT_W'(1);
                    end else begin
                        div_done    = 1'b1;
                        id_ex_flush = 1'b1;
                        w_nextState = ST_RUN;
                    end
                end
                ST_REDIR: begin
                    if_id_flush = 1'b1;
                    if (imem_wait) begin
                        pc_en = 1'b0;
                    end else begin
                        pc_sel_redir = 1'b1;
                        w_nextState  = ST_RUN;
                    end
                end
                default: begin
                    w_nextState = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stallCycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (!pc_en && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
`else
    assign stall_cycles = 32'h0;
`endif

    a_noDivWithBranch : assert property (
        @(posedge clk) disable iff (rst)
        !((r_state == ST_RUN) && div_req && br_taken)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_stall_ctrl
//  Purpose  : Directed self-checking bench for pipe_stall_ctrl (DIV_LAT = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lu_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_wait = 1'b0;
    logic        dmem_wait = 1'b0;
    logic        div_req = 1'b0;
    logic        pc_en, pc_sel_redir, redir_ld;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        div_busy, div_done;
    logic [31:0] stall_cycles;

    int nChecks = 0;
    int nErrors = 0;

    // Output vector order: pc_en, pc_sel_redir, redir_ld, if_id_en, id_ex_en,
    // ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, div_busy, div_done
    localparam logic [11:0] C_ZERO   = 12'h000;
    localparam logic [11:0] C_IDLE   = 12'h9E0;
    localparam logic [11:0] C_LU     = 12'h0E8;
    localparam logic [11:0] C_IMEM   = 12'h1F0;
    localparam logic [11:0] C_BR     = 12'h9F8;
    localparam logic [11:0] C_BRWAIT = 12'h3F8;
    localparam logic [11:0] C_REDIR  = 12'hDF0;
    localparam logic [11:0] C_DIVREQ = 12'h064;
    localparam logic [11:0] C_DIVRUN = 12'h066;
    localparam logic [11:0] C_DIVEND = 12'h0EB;
    localparam logic [11:0] C_DIVDM  = 12'h002;

    localparam logic [4:0] I_NONE = 5'b00000;  // {lu, br, imem, dmem, div}
    localparam logic [4:0] I_LU   = 5'b10000;
    localparam logic [4:0] I_BR   = 5'b01000;
    localparam logic [4:0] I_IMEM = 5'b00100;
    localparam logic [4:0] I_DMEM = 5'b00010;
    localparam logic [4:0] I_DIV  = 5'b00001;

    wire [11:0] outVec = {pc_en, pc_sel_redir, redir_ld, if_id_en, id_ex_en, ex_mem_en,
                          mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, div_busy, div_done};

    pipe_stall_ctrl #(.DIV_LAT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .lu_stall     (lu_stall),
        .br_taken     (br_taken),
        .imem_wait    (imem_wait),
        .dmem_wait    (dmem_wait),
        .div_req      (div_req),
        .pc_en        (pc_en),
        .pc_sel_redir (pc_sel_redir),
        .redir_ld     (redir_ld),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, check the combinational outputs 1ns later.
    task automatic cyc(input string tag, input logic [4:0] in, input logic [11:0] exp);
        @(negedge clk);
        {lu_stall, br_taken, imem_wait, dmem_wait, div_req} = in;
        #1;
        check(tag, {20'h0, outVec}, {20'h0, exp});
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        {lu_stall, br_taken, imem_wait, dmem_wait, div_req} = I_NONE;
        #1;
        check("reset_outputs", {20'h0, outVec}, {20'h0, C_ZERO});
        check("reset_stall_cnt", stall_cycles, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] expStall;

    initial begin
        doReset();

        // T1 load-use and plain RUN priorities
        cyc("t1_lu", I_LU, C_LU);
        cyc("t1_idle", I_NONE, C_IDLE);
        cyc("imem_only", I_IMEM, C_IMEM);
        cyc("br_nowait", I_BR, C_BR);
        cyc("lu_over_imem", I_LU | I_IMEM, C_LU);
        cyc("br_over_lu", I_BR | I_LU, C_BR);
        cyc("dmem_run", I_DMEM | I_BR | I_IMEM, C_ZERO);
        cyc("after_dmem_run", I_NONE, C_IDLE);

        // T2 divide, DIV_LAT = 4; events inside DIV are ignored
        cyc("t2_c0", I_DIV, C_DIVREQ);
        cyc("t2_c1", I_NONE, C_DIVRUN);
        cyc("t2_c2", I_LU | I_IMEM, C_DIVRUN);
        cyc("t2_c3", I_DIV, C_DIVRUN);
        cyc("t2_c4", I_NONE, C_DIVEND);
        cyc("t2_c5", I_NONE, C_IDLE);

        // T3 branch during fetch wait, redirect when the bus frees up
        cyc("t3_c0", I_BR | I_IMEM, C_BRWAIT);
        cyc("t3_c1", I_IMEM, C_IMEM);
        cyc("t3_c2", I_IMEM | I_LU, C_IMEM);
        cyc("t3_c3", I_NONE, C_REDIR);
        cyc("t3_c4", I_NONE, C_IDLE);

        // T4 dmem_wait stretches the divide by two cycles
        cyc("t4_c0", I_DIV, C_DIVREQ);
        cyc("t4_c1", I_NONE, C_DIVRUN);
        cyc("t4_c2", I_DMEM, C_DIVDM);
        cyc("t4_c3", I_DMEM, C_DIVDM);
        cyc("t4_c4", I_NONE, C_DIVRUN);
        cyc("t4_c5", I_NONE, C_DIVRUN);
        cyc("t4_c6", I_NONE, C_DIVEND);
        cyc("t4_c7", I_NONE, C_IDLE);

        // T5 reset while in REDIR discards the pending redirect
        cyc("t5_enter", I_BR | I_IMEM, C_BRWAIT);
        doReset();
        cyc("t5_after", I_NONE, C_IDLE);

        // T6 stall counter: 5 load-use cycles plus a 5-cycle PC hold from the divide
        for (int i = 0; i < 5; i++) cyc("t6_lu", I_LU, C_LU);
        cyc("t6_d0", I_DIV, C_DIVREQ);
        for (int i = 0; i < 3; i++) cyc("t6_dn", I_NONE, C_DIVRUN);
        cyc("t6_d4", I_NONE, C_DIVEND);
        cyc("t6_idle", I_NONE, C_IDLE);
`ifdef PIPE_STALL_CNT_EN
        expStall = 32'd10;
`else
        expStall = 32'd0;
`endif
        check("t6_stall_cycles", stall_cycles, expStall);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
